// File: rtl/alu_core_pkg.sv
// Shared types for the 2A03 ALU stage: operation codes, page-fix direction,
// FSM states and flag bundles.
package alu_core_pkg;

  localparam int ALU_WIDTH = 8;

  // Seventeen operations, so the code needs five bits.
  typedef enum logic [4:0] {
    ALU_ADC    = 5'd0,
    ALU_SBC    = 5'd1,
    ALU_CMP    = 5'd2,
    ALU_AND    = 5'd3,
    ALU_ORA    = 5'd4,
    ALU_EOR    = 5'd5,
    ALU_BIT    = 5'd6,
    ALU_ASL    = 5'd7,
    ALU_LSR    = 5'd8,
    ALU_ROL    = 5'd9,
    ALU_ROR    = 5'd10,
    ALU_INC    = 5'd11,
    ALU_DEC    = 5'd12,
    ALU_PASS   = 5'd13,
    ALU_ADDR   = 5'd14,
    ALU_BRANCH = 5'd15,
    ALU_FIX    = 5'd16
  } alu_op_t;

  typedef enum logic [1:0] {
    FIX_NONE = 2'd0,
    FIX_INC  = 2'd1,
    FIX_DEC  = 2'd2
  } fix_dir_t;

  typedef enum logic {
    IDLE     = 1'b0,
    FIX_PEND = 1'b1
  } fix_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  function automatic logic [ALU_WIDTH-1:0] fix_offset(input fix_dir_t dir);
    logic [ALU_WIDTH-1:0] off;
    case (dir)
      FIX_INC: off = 8'h01;
      FIX_DEC: off = 8'hFF;
      default: off = 8'h00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Combinational op evaluation: result, candidate flags, flag write mask and
// the page-crossing direction for address/branch adds.
module alu_comb
  import alu_core_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  input  fix_dir_t         fix_dir,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output alu_flags_t       wmask,
  output fix_dir_t         fix_need
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] nz_src;

  // Per-op result, carry/overflow, and which flags the op is allowed to write.
  always_comb begin
    sum      = '0;
    diff     = '0;
    b_eff    = in2;
    result   = in1;
    nz_src   = in1;
    flags    = '0;
    wmask    = '0;
    fix_need = FIX_NONE;
    case (op)
      ALU_ADC, ALU_SBC: begin
        b_eff   = (op == ALU_SBC) ? ~in2 : in2;
        sum     = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_in};
        result  = sum[WIDTH-1:0];
        nz_src  = sum[WIDTH-1:0];
        flags.c = sum[WIDTH];
        flags.v = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        wmask   = 4'b1111;
      end
      ALU_CMP: begin
        diff    = {1'b0, in1} - {1'b0, in2};
        nz_src  = diff[WIDTH-1:0];
        flags.c = ~diff[WIDTH];
        wmask   = 4'b1110;
      end
      ALU_AND: begin
        result = in1 & in2;
        nz_src = in1 & in2;
        wmask  = 4'b1100;
      end
      ALU_ORA: begin
        result = in1 | in2;
        nz_src = in1 | in2;
        wmask  = 4'b1100;
      end
      ALU_EOR: begin
        result = in1 ^ in2;
        nz_src = in1 ^ in2;
        wmask  = 4'b1100;
      end
      ALU_BIT: begin
        nz_src  = in1 & in2;
        flags.v = in2[WIDTH-2];
        wmask   = 4'b1101;
      end
      ALU_ASL: begin
        result  = {in1[WIDTH-2:0], 1'b0};
        nz_src  = {in1[WIDTH-2:0], 1'b0};
        flags.c = in1[WIDTH-1];
        wmask   = 4'b1110;
      end
      ALU_LSR: begin
        result  = {1'b0, in1[WIDTH-1:1]};
        nz_src  = {1'b0, in1[WIDTH-1:1]};
        flags.c = in1[0];
        wmask   = 4'b1110;
      end
      ALU_ROL: begin
        result  = {in1[WIDTH-2:0], c_in};
        nz_src  = {in1[WIDTH-2:0], c_in};
        flags.c = in1[WIDTH-1];
        wmask   = 4'b1110;
      end
      ALU_ROR: begin
        result  = {c_in, in1[WIDTH-1:1]};
        nz_src  = {c_in, in1[WIDTH-1:1]};
        flags.c = in1[0];
        wmask   = 4'b1110;
      end
      ALU_INC: begin
        result = in1 + 8'd1;
        nz_src = in1 + 8'd1;
        wmask  = 4'b1100;
      end
      ALU_DEC: begin
        result = in1 - 8'd1;
        nz_src = in1 - 8'd1;
        wmask  = 4'b1100;
      end
      ALU_PASS: begin
        wmask = 4'b1100;
      end
      ALU_ADDR: begin
        sum      = {1'b0, in1} + {1'b0, in2};
        result   = sum[WIDTH-1:0];
        fix_need = sum[WIDTH] ? FIX_INC : FIX_NONE;
      end
      ALU_BRANCH: begin
        // Unsigned carry combined with the offset sign tells which page we left.
        sum    = {1'b0, in1} + {1'b0, in2};
        result = sum[WIDTH-1:0];
        if (sum[WIDTH] && !in2[WIDTH-1]) begin
          fix_need = FIX_INC;
        end else if (!sum[WIDTH] && in2[WIDTH-1]) begin
          fix_need = FIX_DEC;
        end else begin
          fix_need = FIX_NONE;
        end
      end
      ALU_FIX: begin
        result = in1 + fix_offset(fix_dir);
      end
      default: begin
        result = in1;
      end
    endcase
    flags.z = (nz_src == '0);
    flags.n = (op == ALU_BIT) ? in2[WIDTH-1] : nz_src[WIDTH-1];
  end

endmodule

// File: rtl/alu_core.sv
// Registered 8-bit ALU stage: result/flag registers with write mask, carry
// load, and the page-crossing fix-up FSM.
module alu_core
  import alu_core_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             op_valid,
  input  alu_op_t          alu_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_load,
  input  logic             c_val,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             res_valid,
  output logic             fix_req,
  output logic             fix_busy
);

  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             res_valid_q, res_valid_d;
  logic             fix_req_q, fix_req_d;
  fix_dir_t         fix_dir_q, fix_dir_d;
  fix_state_t       state_q, state_d;
  logic             fix_lost_q, fix_lost_d;

  logic             accept;
  logic [WIDTH-1:0] comb_result;
  alu_flags_t       comb_flags;
  alu_flags_t       comb_wmask;
  fix_dir_t         comb_fix;

  assign accept = op_valid && !stall;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (alu_op),
    .in1      (in1),
    .in2      (in2),
    .c_in     (flags_q.c),
    .fix_dir  (fix_dir_q),
    .result   (comb_result),
    .flags    (comb_flags),
    .wmask    (comb_wmask),
    .fix_need (comb_fix)
  );

  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    res_valid_d = res_valid_q;
    if (stall) begin
      res_valid_d = res_valid_q;
    end else begin
      res_valid_d = op_valid;
      if (op_valid) begin
        result_d  = comb_result;
        flags_d.n = comb_wmask.n ? comb_flags.n : flags_q.n;
        flags_d.z = comb_wmask.z ? comb_flags.z : flags_q.z;
        flags_d.v = comb_wmask.v ? comb_flags.v : flags_q.v;
        flags_d.c = comb_wmask.c ? comb_flags.c : flags_q.c;
      end else begin
        result_d = result_q;
      end
      // Explicit carry load overrides whatever the op computed.
      flags_d.c = c_load ? c_val : flags_d.c;
    end
  end

  always_comb begin
    state_d    = state_q;
    fix_dir_d  = fix_dir_q;
    fix_lost_d = fix_lost_q;
    fix_req_d  = fix_req_q;
    if (stall) begin
      fix_req_d = fix_req_q;
    end else begin
      fix_req_d = op_valid && (comb_fix != FIX_NONE);
      if (op_valid) begin
        case (state_q)
          IDLE: begin
            if (comb_fix != FIX_NONE) begin
              state_d   = FIX_PEND;
              fix_dir_d = comb_fix;
            end else begin
              state_d   = IDLE;
              fix_dir_d = FIX_NONE;
            end
          end
          FIX_PEND: begin
            if (alu_op == ALU_FIX) begin
              state_d   = IDLE;
              fix_dir_d = FIX_NONE;
            end else begin
              // Any other op abandons the pending fix; a new crossing re-arms it.
              fix_lost_d = 1'b1;
              state_d    = (comb_fix != FIX_NONE) ? FIX_PEND : IDLE;
              fix_dir_d  = comb_fix;
            end
          end
          default: begin
            state_d   = IDLE;
            fix_dir_d = FIX_NONE;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
      fix_req_q   <= 1'b0;
      fix_dir_q   <= FIX_NONE;
      state_q     <= IDLE;
      fix_lost_q  <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
      fix_req_q   <= fix_req_d;
      fix_dir_q   <= fix_dir_d;
      state_q     <= state_d;
      fix_lost_q  <= fix_lost_d;
    end
  end

  assign result    = result_q;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign res_valid = res_valid_q;
  assign fix_req   = fix_req_q;
  assign fix_busy  = (state_q == FIX_PEND);

endmodule
